// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the fetch PC and drives a 1-cycle-latency instruction BRAM.
// It presents {inst, pc, valid} to decode, with a one-entry skid register to cover decode stalls.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IM_ADDR_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [IM_ADDR_W-1:0] im_addr,
    output logic                 im_re,
    input  logic [31:0]          im_data,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [31:0]          redirect_pc,
    output logic [31:0]          id_inst,
    output logic [31:0]          id_pc,
    output logic                 id_valid,
    output logic                 id_exc_misaligned
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        S_RUN,
        S_TRAP
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc_f, pc_f_next;
    logic        req_valid, req_valid_next;
    logic [31:0] req_pc, req_pc_next;
    logic        hold_valid, hold_valid_next;
    logic [31:0] hold_inst, hold_inst_next;
    logic [31:0] hold_pc, hold_pc_next;
    logic [31:0] trap_pc, trap_pc_next;
    logic        redirect_aligned;

    assign redirect_aligned = (redirect_pc[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_RUN;
            pc_f       <= RESET_PC;
            req_valid  <= 1'b0;
            req_pc     <= 32'h0;
            hold_valid <= 1'b0;
            hold_inst  <= NOP;
            hold_pc    <= 32'h0;
            trap_pc    <= 32'h0;
        end else begin
            state      <= state_next;
            pc_f       <= pc_f_next;
            req_valid  <= req_valid_next;
            req_pc     <= req_pc_next;
            hold_valid <= hold_valid_next;
            hold_inst  <= hold_inst_next;
            hold_pc    <= hold_pc_next;
            trap_pc    <= trap_pc_next;
        end
    end

    // Priority: redirect, then trap parking, then stall, then normal issue.
    always_comb begin
        state_next      = state;
        pc_f_next       = pc_f;
        req_valid_next  = req_valid;
        req_pc_next     = req_pc;
        hold_valid_next = hold_valid;
        hold_inst_next  = hold_inst;
        hold_pc_next    = hold_pc;
        trap_pc_next    = trap_pc;
        im_re           = 1'b0;
        im_addr         = pc_f[IM_ADDR_W+1:2];

        if (redirect) begin
            hold_valid_next = 1'b0;
            if (redirect_aligned) begin
                im_re          = 1'b1;
                im_addr        = redirect_pc[IM_ADDR_W+1:2];
                req_pc_next    = redirect_pc;
                req_valid_next = 1'b1;
                pc_f_next      = redirect_pc + 32'd4;
                state_next     = S_RUN;
            end else begin
                req_valid_next = 1'b0;
                trap_pc_next   = redirect_pc;
                state_next     = S_TRAP;
            end
        end else if (state == S_TRAP) begin
            state_next = S_TRAP;
        end else if (stall) begin
            // Park the in-flight BRAM word, because im_data will not persist past this cycle.
            if (req_valid && !hold_valid) begin
                hold_inst_next  = im_data;
                hold_pc_next    = req_pc;
                hold_valid_next = 1'b1;
                req_valid_next  = 1'b0;
            end
        end else begin
            hold_valid_next = 1'b0;
            im_re           = 1'b1;
            req_pc_next     = pc_f;
            req_valid_next  = 1'b1;
            pc_f_next       = pc_f + 32'd4;
        end

        if (reset) begin
            im_re = 1'b0;
        end
    end

    always_comb begin
        id_inst           = NOP;
        id_pc             = 32'h0;
        id_valid          = 1'b0;
        id_exc_misaligned = 1'b0;
        if (reset) begin
            id_valid = 1'b0;
        end else if (state == S_TRAP) begin
            id_pc             = trap_pc;
            id_valid          = 1'b1;
            id_exc_misaligned = 1'b1;
        end else if (hold_valid) begin
            id_inst  = hold_inst;
            id_pc    = hold_pc;
            id_valid = 1'b1;
        end else if (req_valid) begin
            id_inst  = im_data;
            id_pc    = req_pc;
            id_valid = 1'b1;
        end
    end

endmodule
